// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared definitions for the memory/writeback stage
// Purpose: funct3 load/store encodings, FSM state enum and enable constants.
// Ports: none (package).
package mem_wb_stage_pkg;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   // RV32I funct3 encodings for loads and stores
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic {
      IDLE = 1'b0,
      MEM  = 1'b1
   } state_t;

endpackage

// File: rtl/mem_wb_stage_align.sv
// rtl/mem_wb_stage_align.sv - byte-lane steering, alignment check and load extraction
// Purpose: pure combinational helper for mem_wb_stage.
// Ports: is_store/funct3/addr_lo select the access shape; store_data feeds the
//        store lanes (be, wdata); rdata feeds load_data; misalign flags an
//        access whose address is not a multiple of its size.
module mem_align
   import mem_wb_stage_pkg::*;
(
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic        misalign,
   output logic [31:0] load_data
);

   logic [31:0] shifted;

   always_comb begin
      be       = 4'hF;
      wdata    = store_data;
      misalign = 1'b0;
      if (is_store) begin
         case (funct3)
            F3_SB: begin
               be    = 4'b0001 << addr_lo;
               wdata = {4{store_data[7:0]}};
            end
            F3_SH: begin
               be       = 4'b0011 << addr_lo;
               wdata    = {2{store_data[15:0]}};
               misalign = addr_lo[0];
            end
            F3_SW:   misalign = |addr_lo;
            // unsupported encodings are treated as word accesses
            default: misalign = |addr_lo;
         endcase
      end else begin
         case (funct3)
            F3_LB, F3_LBU: misalign = 1'b0;
            F3_LH, F3_LHU: misalign = addr_lo[0];
            F3_LW:         misalign = |addr_lo;
            default:       misalign = |addr_lo;
         endcase
      end
   end

   // bring the addressed byte/half down to bit 0 before extension
   assign shifted = rdata >> {addr_lo, 3'b000};

   always_comb begin
      case (funct3)
         F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_LBU:  load_data = {24'd0, shifted[7:0]};
         F3_LHU:  load_data = {16'd0, shifted[15:0]};
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory access and register writeback pipeline stage
// Purpose: accepts execute results, runs loads/stores over a req/ack data
//          memory handshake and drives one-cycle register-file writebacks.
// Ports: clk/rst (sync, active-high); EX_* execute result inputs;
//        mem_stall back-pressure to execute; dmem_* memory request/response;
//        w_enable_WB/w_addr_WB/w_data_WB/pc_WB writeback port;
//        halt_WB sticky halt flag; misalign_WB one-cycle dropped-access pulse.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              EX_valid,
   input  logic [XLEN-1:0]   EX_pc,
   input  logic [XLEN-1:0]   EX_alu_result,
   input  logic [XLEN-1:0]   EX_rs2_data,
   input  logic [REG_AW-1:0] EX_rd_addr,
   input  logic              EX_w_enable,
   input  logic              EX_is_load,
   input  logic              EX_is_store,
   input  logic              EX_is_halt,
   input  logic [2:0]        EX_funct3,
   output logic              mem_stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [XLEN-1:0]   dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic [XLEN-1:0]   dmem_rdata,
   input  logic              dmem_ack,
   output logic              w_enable_WB,
   output logic [REG_AW-1:0] w_addr_WB,
   output logic [XLEN-1:0]   w_data_WB,
   output logic [XLEN-1:0]   pc_WB,
   output logic              halt_WB,
   output logic              misalign_WB
);

   state_t            state, state_nxt;
   logic [REG_AW-1:0] rd_q;
   logic [XLEN-1:0]   pc_q;
   logic [2:0]        f3_q;
   logic [1:0]        addr_lo_q;
   logic              is_load_q;

   logic              accept, is_mem, go_mem;
   logic [3:0]        al_be;
   logic [XLEN-1:0]   al_wdata, al_load;
   logic              al_misalign;

   assign accept = (state == IDLE) && EX_valid && !halt_WB;
   assign is_mem = EX_is_load || EX_is_store;
   assign go_mem = accept && !EX_is_halt && is_mem && !al_misalign;

   // In IDLE the helper looks at the incoming instruction (lanes, alignment);
   // in MEM it looks at the saved access shape to extract the load result.
   mem_align u_align (
      .is_store   (EX_is_store),
      .funct3     ((state == MEM) ? f3_q : EX_funct3),
      .addr_lo    ((state == MEM) ? addr_lo_q : EX_alu_result[1:0]),
      .store_data (EX_rs2_data),
      .rdata      (dmem_rdata),
      .be         (al_be),
      .wdata      (al_wdata),
      .misalign   (al_misalign),
      .load_data  (al_load)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (go_mem)   state_nxt = MEM;
         MEM:  if (dmem_ack) state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_stall = (state == MEM) ? ENABLE : DISABLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dmem_req    <= DISABLE;
         dmem_we     <= DISABLE;
         dmem_addr   <= '0;
         dmem_wdata  <= '0;
         dmem_be     <= '0;
         w_enable_WB <= DISABLE;
         w_addr_WB   <= '0;
         w_data_WB   <= '0;
         pc_WB       <= '0;
         halt_WB     <= DISABLE;
         misalign_WB <= DISABLE;
         rd_q        <= '0;
         pc_q        <= '0;
         f3_q        <= '0;
         addr_lo_q   <= '0;
         is_load_q   <= DISABLE;
      end else begin
         w_enable_WB <= DISABLE;
         misalign_WB <= DISABLE;
         if (state == IDLE) begin
            if (accept) begin
               if (EX_is_halt) begin
                  halt_WB <= ENABLE;
               end else if (is_mem) begin
                  if (al_misalign) begin
                     misalign_WB <= ENABLE;
                  end else begin
                     dmem_req   <= ENABLE;
                     dmem_we    <= EX_is_store;
                     dmem_addr  <= {EX_alu_result[XLEN-1:2], 2'b00};
                     dmem_wdata <= al_wdata;
                     dmem_be    <= al_be;
                     rd_q       <= EX_rd_addr;
                     pc_q       <= EX_pc;
                     f3_q       <= EX_funct3;
                     addr_lo_q  <= EX_alu_result[1:0];
                     is_load_q  <= !EX_is_store;
                  end
               end else begin
                  w_enable_WB <= EX_w_enable && (EX_rd_addr != '0);
                  w_addr_WB   <= EX_rd_addr;
                  w_data_WB   <= EX_alu_result;
                  pc_WB       <= EX_pc;
               end
            end
         end else if (dmem_ack) begin
            dmem_req <= DISABLE;
            pc_WB    <= pc_q;
            if (is_load_q) begin
               w_enable_WB <= (rd_q != '0);
               w_addr_WB   <= rd_q;
               w_data_WB   <= al_load;
            end
         end
      end
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access and writeback pipeline stage. It sits after execute and is the writer of the WB register-file write port that the decode stage consumes (w_enable_WB / w_addr_WB / w_data_WB / pc_WB). It runs loads and stores to data memory over a req/ack handshake, back-pressures execute while an access is outstanding, and emits exactly one single-cycle writeback per retired instruction.

Parameters:
XLEN, 32, datapath/address width; only 32 is supported.
REG_AW, 5, register address width.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
EX_valid  in  1  execute result valid this cycle
EX_pc  in  XLEN  pc of instruction
EX_alu_result  in  XLEN  ALU result / memory address
EX_rs2_data  in  XLEN  store data
EX_rd_addr  in  REG_AW  destination register
EX_w_enable  in  1  instruction writes rd
EX_is_load  in  1  load instruction
EX_is_store  in  1  store instruction
EX_is_halt  in  1  halt instruction
EX_funct3  in  3  access size/sign (RV32I encoding)
mem_stall  out  1  execute must hold; EX_valid is ignored while high
dmem_req  out  1  memory request
dmem_we  out  1  1 = store
dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  out  XLEN  lane-replicated store data
dmem_be  out  4  byte enables
dmem_rdata  in  XLEN  load data, valid with ack
dmem_ack  in  1  request complete
w_enable_WB  out  1  register write strobe
w_addr_WB  out  REG_AW  write address
w_data_WB  out  XLEN  write data
pc_WB  out  XLEN  pc of retiring instruction
halt_WB  out  1  sticky: halt retired
misalign_WB  out  1  one-cycle pulse: misaligned access dropped

Behaviour:
- Reset: every output is 0, FSM = IDLE, and any outstanding request is abandoned. The stage does not wait for an ack.
- FSM states:
  - IDLE: accepts when EX_valid && !halt_WB.
  - MEM: access outstanding.
- Non-memory instruction accepted in IDLE, cycle T:
  - In T+1: w_enable_WB = EX_w_enable && rd != 0, w_data_WB = alu_result, w_addr_WB and pc_WB loaded.
  - Latency is 1 cycle.
- Load/store accepted in IDLE at T:
  - If aligned: registers drive dmem_req=1 from T+1; state goes to MEM.
  - Alignment rules: SH/LH/LHU need addr[0]=0; SW/LW need addr[1:0]=0.
- MEM:
  - mem_stall = 1. dmem_req and all dmem_* outputs are held stable until dmem_ack.
  - An ack in the first req cycle is legal.
  - On the ack cycle A: dmem_req drops at A+1 and state returns to IDLE at A+1. mem_stall is low in A+1, so a new instruction may be accepted in A+1.
  - Load: rdata is captured at A. At A+1, w_enable_WB = (rd != 0).
  - Store: no register write. pc_WB is updated at A+1.
- Store lanes:
  - SB: be = 1 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011 << addr[1:0], wdata = {2{rs2[15:0]}}.
  - SW: be = 4'hF.
  - Loads use be = 4'hF.
- Load extract:
  - Shift rdata right by 8*addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Unsupported funct3 values behave as LW/SW.
- Misaligned access: no dmem_req and no register write. misalign_WB pulses at T+1 and FSM stays IDLE.
- Halt: at T+1, halt_WB=1 and stays set until reset. All later EX_valid is ignored and there is no writeback.
- w_enable_WB and misalign_WB are high for one cycle only. w_addr_WB, w_data_WB and pc_WB hold their last values otherwise.
- rd == 0 never produces w_enable_WB.

Decomposition:
- Shared package (existing define package) holds:
  - funct3 load/store encodings (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - the FSM state enum {IDLE, MEM};
  - ENABLE/DISABLE constants.
- One combinational sub-module, mem_align: computes be, wdata, misalign and load extraction from funct3, addr[1:0] and rdata. The FSM and WB registers stay in mem_wb_stage.

Test Plan:
- ALU op: EX rd=5, alu_result=32'h1234 at T -> at T+1 w_enable_WB=1, w_addr_WB=5, w_data_WB=32'h1234 for one cycle. Repeat with rd=0 -> w_enable_WB stays 0.
- LB: addr=32'h103, mem word 32'h80_00_00_00, ack delayed 3 cycles -> dmem_addr=32'h100 with mem_stall high throughout; one cycle after ack w_data_WB=32'hFFFFFF80. The same case with LBU gives 32'h00000080.
- SH: addr=32'h202, rs2=32'hABCD1234 -> dmem_be=4'b1100, dmem_wdata=32'h12341234, dmem_we=1; no w_enable_WB.
- Misaligned: LW at addr 32'h2 -> no dmem_req; misalign_WB pulses 1 cycle; the next instruction is accepted normally.
- Back-to-back: a load whose ack arrives in the first req cycle, followed immediately by an ALU op -> two consecutive w_enable_WB pulses, both with correct data.
- rst asserted while in MEM with no ack -> next cycle dmem_req=0, mem_stall=0, all outputs 0. After a halt, EX_valid pulses produce no writeback and halt_WB stays 1.
